// File: rtl/i2c_eeprom_slave.sv
// 24C02-style I2C EEPROM responder: 256x8 register array behind a filtered SCL/SDA front end.
// Supports byte/sequential write and current/random/sequential read, plus a registered host debug read port.
module i2c_eeprom_slave #(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int         FILT_LEN = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SCL,
  inout  logic       SDA,
  output logic       Wr_Strobe,
  output logic [7:0] Wr_Addr,
  output logic [7:0] Wr_Data,
  output logic       Busy,
  input  logic [7:0] Dbg_Addr,
  output logic [7:0] Dbg_Data
);

  localparam int CW = $clog2(FILT_LEN + 1);

  typedef enum logic [3:0] {
    IDLE, DEV, DEV_ACK, WADDR, WADDR_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT_STOP
  } state_t;

  logic [1:0] raw;
  logic [1:0] filt;
  assign raw = {SDA, SCL};

  // Per-line synchroniser plus glitch filter; index 0 = SCL, 1 = SDA.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_filt
      logic          s1_reg;
      logic          s2_reg;
      logic          f_reg;
      logic [CW-1:0] cnt_reg;

      always_ff @(posedge CLK) begin
        if (RST) begin
          s1_reg  <= 1'b1;
          s2_reg  <= 1'b1;
          f_reg   <= 1'b1;
          cnt_reg <= '0;
        end else begin
          s1_reg <= raw[gi];
          s2_reg <= s1_reg;
          if (s2_reg == f_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CW'(FILT_LEN - 1)) begin
            f_reg   <= s2_reg;
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign filt[gi] = f_reg;
    end
  endgenerate

  logic scl_f, sda_f;
  logic scl_d_reg, sda_d_reg;
  assign scl_f = filt[0];
  assign sda_f = filt[1];

  always_ff @(posedge CLK) begin
    if (RST) begin
      scl_d_reg <= 1'b1;
      sda_d_reg <= 1'b1;
    end else begin
      scl_d_reg <= scl_f;
      sda_d_reg <= sda_f;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_f & ~scl_d_reg;
  assign scl_fall  = ~scl_f & scl_d_reg;
  assign start_det = scl_f & scl_d_reg & sda_d_reg & ~sda_f;
  assign stop_det  = scl_f & scl_d_reg & ~sda_d_reg & sda_f;

  state_t     state_reg;
  logic [7:0] ptr_reg;
  logic [3:0] bit_cnt_reg;
  logic [7:0] shift_reg;
  logic       sda_oe_reg;
  logic [7:0] rd_data_reg;
  logic [7:0] mem [0:255];

  logic       rx_state, rx_bit, wr_en;
  logic [7:0] wr_byte;
  assign rx_state = (state_reg == DEV) || (state_reg == WADDR) || (state_reg == WDATA);
  assign rx_bit   = scl_rise && rx_state && (bit_cnt_reg != 4'd8) && !start_det && !stop_det;
  assign wr_byte  = {shift_reg[6:0], sda_f};
  assign wr_en    = rx_bit && (state_reg == WDATA) && (bit_cnt_reg == 4'd7);

  assign SDA = sda_oe_reg ? 1'b0 : 1'bz;

  always_ff @(posedge CLK) begin
    if (wr_en) mem[ptr_reg] <= wr_byte;
  end

  // Read-before-write: a same-cycle bus write is seen one cycle later on both read ports.
  always_ff @(posedge CLK) begin
    rd_data_reg <= mem[ptr_reg];
    if (RST) Dbg_Data <= 8'h00;
    else     Dbg_Data <= mem[Dbg_Addr];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg   <= IDLE;
      sda_oe_reg  <= 1'b0;
      Busy        <= 1'b0;
      Wr_Strobe   <= 1'b0;
      Wr_Addr     <= 8'h00;
      Wr_Data     <= 8'h00;
      ptr_reg     <= 8'h00;
      bit_cnt_reg <= 4'd0;
      shift_reg   <= 8'h00;
    end else begin
      Wr_Strobe <= 1'b0;
      if (stop_det) begin
        state_reg  <= IDLE;
        sda_oe_reg <= 1'b0;
        Busy       <= 1'b0;
      end else if (start_det) begin
        state_reg   <= DEV;
        bit_cnt_reg <= 4'd0;
        sda_oe_reg  <= 1'b0;
      end else begin
        if (rx_bit) begin
          shift_reg   <= wr_byte;
          bit_cnt_reg <= bit_cnt_reg + 4'd1;
        end
        case (state_reg)
          DEV: if (scl_fall && bit_cnt_reg == 4'd8) begin
            if (shift_reg[7:1] == DEV_ADDR) begin
              state_reg  <= DEV_ACK;
              sda_oe_reg <= 1'b1;
              Busy       <= 1'b1;
            end else begin
              state_reg <= IDLE;
              Busy      <= 1'b0;
            end
          end
          DEV_ACK: if (scl_fall) begin
            if (shift_reg[0]) begin
              state_reg   <= RDATA;
              shift_reg   <= rd_data_reg;
              sda_oe_reg  <= ~rd_data_reg[7];
              bit_cnt_reg <= 4'd1;
            end else begin
              state_reg   <= WADDR;
              sda_oe_reg  <= 1'b0;
              bit_cnt_reg <= 4'd0;
            end
          end
          WADDR: if (scl_fall && bit_cnt_reg == 4'd8) begin
            ptr_reg    <= shift_reg;
            sda_oe_reg <= 1'b1;
            state_reg  <= WADDR_ACK;
          end
          WADDR_ACK, WDATA_ACK: if (scl_fall) begin
            sda_oe_reg  <= 1'b0;
            bit_cnt_reg <= 4'd0;
            state_reg   <= WDATA;
          end
          WDATA: begin
            if (wr_en) begin
              Wr_Strobe <= 1'b1;
              Wr_Addr   <= ptr_reg;
              Wr_Data   <= wr_byte;
            end
            if (scl_fall && bit_cnt_reg == 4'd8) begin
              sda_oe_reg <= 1'b1;
              ptr_reg    <= ptr_reg + 8'd1;
              state_reg  <= WDATA_ACK;
            end
          end
          // bit_cnt 0 marks a byte still to be loaded after a master ACK.
          RDATA: if (scl_fall) begin
            if (bit_cnt_reg == 4'd0) begin
              shift_reg   <= rd_data_reg;
              sda_oe_reg  <= ~rd_data_reg[7];
              bit_cnt_reg <= 4'd1;
            end else if (bit_cnt_reg == 4'd8) begin
              sda_oe_reg  <= 1'b0;
              bit_cnt_reg <= 4'd0;
              state_reg   <= RACK;
            end else begin
              shift_reg   <= {shift_reg[6:0], 1'b0};
              sda_oe_reg  <= ~shift_reg[6];
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
            end
          end
          RACK: if (scl_rise) begin
            if (!sda_f) begin
              ptr_reg     <= ptr_reg + 8'd1;
              bit_cnt_reg <= 4'd0;
              state_reg   <= RDATA;
            end else begin
              state_reg <= WAIT_STOP;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Directed bench for i2c_eeprom_slave: a bit-banged I2C master drives writes, reads, glitches and resets.
module tb_i2c_eeprom_slave;
  localparam int Q = 10;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       SCL = 1'b1;
  logic       sda_low = 1'b0;
  logic [7:0] Dbg_Addr = 8'h00;
  wire        sda;
  logic       Wr_Strobe, Busy;
  logic [7:0] Wr_Addr, Wr_Data, Dbg_Data;

  int         total = 0;
  int         bad = 0;
  int         strobe_cnt = 0;
  logic [7:0] last_addr = 8'h00;
  logic [7:0] last_data = 8'h00;
  logic       busy_seen = 1'b0;

  assign sda = sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 CLK = ~CLK;

  i2c_eeprom_slave #(.DEV_ADDR(7'h50), .FILT_LEN(3)) dut (
    .CLK(CLK), .RST(RST), .SCL(SCL), .SDA(sda),
    .Wr_Strobe(Wr_Strobe), .Wr_Addr(Wr_Addr), .Wr_Data(Wr_Data),
    .Busy(Busy), .Dbg_Addr(Dbg_Addr), .Dbg_Data(Dbg_Data)
  );

  always @(negedge CLK) begin
    if (Wr_Strobe === 1'b1) begin
      strobe_cnt = strobe_cnt + 1;
      last_addr  = Wr_Addr;
      last_data  = Wr_Data;
    end
    if (Busy === 1'b1) busy_seen = 1'b1;
  end

  task automatic ticks(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic clock_bit(input logic b, input logic glitch, output logic rd);
    sda_low = ~b;
    ticks(Q);
    SCL = 1'b1;
    ticks(Q);
    rd = sda;
    if (glitch) begin
      SCL = 1'b0;
      ticks(2);
      SCL = 1'b1;
    end
    ticks(Q);
    SCL = 1'b0;
    ticks(Q);
  endtask

  task automatic i2c_start();
    sda_low = 1'b0;
    ticks(Q);
    SCL = 1'b1;
    ticks(2 * Q);
    sda_low = 1'b1;
    ticks(2 * Q);
    SCL = 1'b0;
    ticks(Q);
  endtask

  task automatic i2c_stop();
    sda_low = 1'b1;
    ticks(Q);
    SCL = 1'b1;
    ticks(2 * Q);
    sda_low = 1'b0;
    ticks(2 * Q);
  endtask

  task automatic write_byte(input logic [7:0] d, input logic glitch, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clock_bit(d[i], glitch, r);
    clock_bit(1'b1, glitch, r);
    ack = (r === 1'b0);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d, output logic ack_line);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, 1'b0, r);
      d[i] = r;
    end
    clock_bit(~mack, 1'b0, ack_line);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    ticks(5);
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", Busy); end
    total++; if (Wr_Strobe !== 1'b0) begin bad++; $display("FAIL reset_strobe got=%b exp=0", Wr_Strobe); end
    total++; if (Wr_Addr !== 8'h00) begin bad++; $display("FAIL reset_wr_addr got=%h exp=00", Wr_Addr); end
    total++; if (Wr_Data !== 8'h00) begin bad++; $display("FAIL reset_wr_data got=%h exp=00", Wr_Data); end
    total++; if (Dbg_Data !== 8'h00) begin bad++; $display("FAIL reset_dbg_data got=%h exp=00", Dbg_Data); end
    total++; if (sda !== 1'b1) begin bad++; $display("FAIL reset_sda got=%b exp=1", sda); end
    RST = 1'b0;
    ticks(10);
    $display("reset: busy=%b sda=%b", Busy, sda);
  endtask

  task automatic test_byte_write();
    logic a0, a1, a2;
    int   s0;
    s0 = strobe_cnt;
    i2c_start();
    write_byte(8'hA0, 1'b0, a0);
    total++; if (Busy !== 1'b1) begin bad++; $display("FAIL t1_busy got=%b exp=1", Busy); end
    write_byte(8'h00, 1'b0, a1);
    write_byte(8'h12, 1'b0, a2);
    i2c_stop();
    total++; if ({a0, a1, a2} !== 3'b111) begin bad++; $display("FAIL t1_acks got=%b exp=111", {a0, a1, a2}); end
    total++; if (strobe_cnt - s0 !== 1) begin bad++; $display("FAIL t1_strobes got=%0d exp=1", strobe_cnt - s0); end
    total++; if (last_addr !== 8'h00) begin bad++; $display("FAIL t1_wr_addr got=%h exp=00", last_addr); end
    total++; if (last_data !== 8'h12) begin bad++; $display("FAIL t1_wr_data got=%h exp=12", last_data); end
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL t1_busy_after_stop got=%b exp=0", Busy); end
    Dbg_Addr = 8'h00;
    ticks(3);
    total++; if (Dbg_Data !== 8'h12) begin bad++; $display("FAIL t1_dbg got=%h exp=12", Dbg_Data); end
    $display("byte write: acks=%b addr=%h data=%h dbg=%h", {a0, a1, a2}, last_addr, last_data, Dbg_Data);
  endtask

  task automatic test_random_read();
    logic       a0, a1, a2, a3, al;
    logic [7:0] d;
    int         s0;
    s0 = strobe_cnt;
    i2c_start();
    write_byte(8'hA0, 1'b0, a0);
    write_byte(8'h00, 1'b0, a1);
    write_byte(8'h12, 1'b0, a2);
    write_byte(8'h34, 1'b0, a3);
    i2c_stop();
    total++; if (strobe_cnt - s0 !== 2) begin bad++; $display("FAIL t2_preload_strobes got=%0d exp=2", strobe_cnt - s0); end
    total++; if (last_addr !== 8'h01 || last_data !== 8'h34) begin
      bad++; $display("FAIL t2_preload_last got=%h/%h exp=01/34", last_addr, last_data);
    end
    i2c_start();
    write_byte(8'hA0, 1'b0, a0);
    write_byte(8'h00, 1'b0, a1);
    i2c_start();
    write_byte(8'hA1, 1'b0, a2);
    read_byte(1'b0, d, al);
    total++; if ({a0, a1, a2} !== 3'b111) begin bad++; $display("FAIL t2_acks got=%b exp=111", {a0, a1, a2}); end
    total++; if (d !== 8'h12) begin bad++; $display("FAIL t2_read_data got=%h exp=12", d); end
    total++; if (al !== 1'b1) begin bad++; $display("FAIL t2_ack_slot_sda got=%b exp=1", al); end
    ticks(Q);
    total++; if (sda !== 1'b1) begin bad++; $display("FAIL t2_sda_released got=%b exp=1", sda); end
    i2c_stop();
    $display("random read: data=%h ack_slot=%b", d, al);
  endtask

  task automatic test_seq_wrap();
    logic       a0, a1, a2, a3, al;
    logic [7:0] d0, d1;
    int         s0;
    s0 = strobe_cnt;
    i2c_start();
    write_byte(8'hA0, 1'b0, a0);
    write_byte(8'hFF, 1'b0, a1);
    write_byte(8'hAA, 1'b0, a2);
    write_byte(8'h55, 1'b0, a3);
    i2c_stop();
    total++; if (strobe_cnt - s0 !== 2) begin bad++; $display("FAIL t3_strobes got=%0d exp=2", strobe_cnt - s0); end
    total++; if (last_addr !== 8'h00 || last_data !== 8'h55) begin
      bad++; $display("FAIL t3_wrap_write got=%h/%h exp=00/55", last_addr, last_data);
    end
    i2c_start();
    write_byte(8'hA0, 1'b0, a0);
    write_byte(8'hFF, 1'b0, a1);
    i2c_start();
    write_byte(8'hA1, 1'b0, a2);
    read_byte(1'b1, d0, al);
    read_byte(1'b0, d1, al);
    i2c_stop();
    total++; if (d0 !== 8'hAA) begin bad++; $display("FAIL t3_byte0 got=%h exp=aa", d0); end
    total++; if (d1 !== 8'h55) begin bad++; $display("FAIL t3_byte1 got=%h exp=55", d1); end
    $display("sequential wrap: bytes=%h %h", d0, d1);
  endtask

  task automatic test_wrong_addr();
    logic a0, a1, a2;
    int   s0;
    s0 = strobe_cnt;
    busy_seen = 1'b0;
    i2c_start();
    write_byte(8'hA2, 1'b0, a0);
    write_byte(8'h00, 1'b0, a1);
    write_byte(8'h77, 1'b0, a2);
    i2c_stop();
    total++; if ({a0, a1, a2} !== 3'b000) begin bad++; $display("FAIL t4_acks got=%b exp=000", {a0, a1, a2}); end
    total++; if (strobe_cnt - s0 !== 0) begin bad++; $display("FAIL t4_strobes got=%0d exp=0", strobe_cnt - s0); end
    total++; if (busy_seen !== 1'b0) begin bad++; $display("FAIL t4_busy_seen got=%b exp=0", busy_seen); end
    Dbg_Addr = 8'h00;
    ticks(3);
    total++; if (Dbg_Data !== 8'h55) begin bad++; $display("FAIL t4_mem_unchanged got=%h exp=55", Dbg_Data); end
    $display("wrong address: acks=%b busy_seen=%b mem0=%h", {a0, a1, a2}, busy_seen, Dbg_Data);
  endtask

  task automatic test_glitch();
    logic a0, a1, a2;
    int   s0;
    s0 = strobe_cnt;
    i2c_start();
    write_byte(8'hA0, 1'b1, a0);
    write_byte(8'h10, 1'b1, a1);
    write_byte(8'h3C, 1'b1, a2);
    i2c_stop();
    total++; if ({a0, a1, a2} !== 3'b111) begin bad++; $display("FAIL t5_acks got=%b exp=111", {a0, a1, a2}); end
    total++; if (strobe_cnt - s0 !== 1) begin bad++; $display("FAIL t5_strobes got=%0d exp=1", strobe_cnt - s0); end
    total++; if (last_addr !== 8'h10 || last_data !== 8'h3C) begin
      bad++; $display("FAIL t5_write got=%h/%h exp=10/3c", last_addr, last_data);
    end
    Dbg_Addr = 8'h10;
    ticks(3);
    total++; if (Dbg_Data !== 8'h3C) begin bad++; $display("FAIL t5_dbg got=%h exp=3c", Dbg_Data); end
    $display("glitch write: acks=%b addr=%h data=%h", {a0, a1, a2}, last_addr, last_data);
  endtask

  task automatic test_reset_mid_read();
    logic       a0, a1, a2, al;
    logic [7:0] d;
    i2c_start();
    write_byte(8'hA0, 1'b0, a0);
    write_byte(8'h00, 1'b0, a1);
    i2c_start();
    write_byte(8'hA1, 1'b0, a2);
    // mem[0x00] = 0x55, so the slave is now holding SDA low for the MSB.
    total++; if (sda !== 1'b0) begin bad++; $display("FAIL t6_driving_low got=%b exp=0", sda); end
    RST = 1'b1;
    ticks(1);
    total++; if (sda !== 1'b1) begin bad++; $display("FAIL t6_sda_released got=%b exp=1", sda); end
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL t6_busy got=%b exp=0", Busy); end
    ticks(3);
    RST = 1'b0;
    ticks(10);
    i2c_start();
    write_byte(8'hA1, 1'b0, a0);
    read_byte(1'b0, d, al);
    i2c_stop();
    total++; if (a0 !== 1'b1) begin bad++; $display("FAIL t6_ack_after_reset got=%b exp=1", a0); end
    total++; if (d !== 8'h55) begin bad++; $display("FAIL t6_current_read got=%h exp=55", d); end
    $display("reset mid-read: current read=%h", d);
  endtask

  initial begin
    test_reset();
    test_byte_write();
    test_random_read();
    test_seq_wrap();
    test_wrong_addr();
    test_glitch();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
